// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: receive front end for the UART.
// A two-flop synchroniser feeds an oversampling 8N1 deserialiser. Each bit is
// sampled at mid-bit with a fixed clocks-per-bit divider. A good frame
// updates data_out and pulses done. A bad stop bit raises a sticky err and
// parks the FSM until the line returns high.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       done,
  output logic       err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, rxs_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Two-flop synchroniser; both flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= data_in;
      rxs_q   <= sync1_q;
    end
  end

  // FSM, counters, shift register and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; losing rx_en mid-frame wins over any sample on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (rx_en && !rxs_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (!rx_en) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MID) begin
          if (!rxs_q) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
            sh_d    = '0;
          end else begin
            // Line went back high before mid start bit: a glitch, not a frame.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (!rx_en) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          sh_d[idx_q] = rxs_q;
          cnt_d       = '0;
          idx_d       = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (!rx_en) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            data_d  = sh_q;
            done_d  = 1'b1;
            err_d   = 1'b0;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_HIGH: begin
        // A held-low line (break) must not be mistaken for a new start bit.
        if (rxs_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_out = data_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
